// File: rtl/nano6502_pkg.sv
// Shared nano6502 definitions: DMA register offsets, CTRL bit positions, DMA FSM encoding.
package nano6502_pkg;

  localparam logic [3:0] DMA_SRC_L = 4'h0;
  localparam logic [3:0] DMA_SRC_H = 4'h1;
  localparam logic [3:0] DMA_DST_L = 4'h2;
  localparam logic [3:0] DMA_DST_H = 4'h3;
  localparam logic [3:0] DMA_LEN_L = 4'h4;
  localparam logic [3:0] DMA_LEN_H = 4'h5;
  localparam logic [3:0] DMA_CTRL  = 4'h6;
  localparam logic [3:0] DMA_FILL  = 4'h7;

  // CTRL write-side bits
  localparam int unsigned CTRL_START    = 0;
  localparam int unsigned CTRL_FILL     = 1;
  localparam int unsigned CTRL_IRQ_EN   = 2;
  localparam int unsigned CTRL_ABORT    = 3;
  localparam int unsigned CTRL_CLR_DONE = 6;
  // CTRL read-side status bits
  localparam int unsigned CTRL_ABORTED  = 5;
  localparam int unsigned CTRL_DONE     = 6;
  localparam int unsigned CTRL_BUSY     = 7;

  typedef enum logic [2:0] {
    DMA_IDLE = 3'd0,
    DMA_REQ  = 3'd1,
    DMA_RD   = 3'd2,
    DMA_RDW  = 3'd3,
    DMA_WR   = 3'd4
  } dma_state_e;

endpackage

// File: rtl/dma_engine.sv
// Byte-wide memory-to-memory DMA with fill mode, abort and level completion interrupt.
module dma_engine
  import nano6502_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        R_W_n,
  input  logic [3:0]  reg_addr_i,
  input  logic [7:0]  data_i,
  input  logic        dma_cs,
  output logic [7:0]  data_o,
  output logic        bus_req_o,
  input  logic        bus_gnt_i,
  output logic [15:0] m_addr_o,
  input  logic [7:0]  m_data_i,
  output logic [7:0]  m_data_o,
  output logic        m_we_o,
  output logic        irq_o
);

  dma_state_e  state_q, state_d;
  logic [15:0] src_q, dst_q, len_q, len_dec;
  logic [7:0]  fill_q, buf_q, ctrl_rd;
  logic        fill_mode_q, irq_en_q, done_q, aborted_q, abort_pend_q, zlen_q;
  logic        reg_wr, ctrl_wr, busy, start_cmd, abort_now;
  logic        step, stop_ok, stop_abort;

  assign reg_wr    = dma_cs & ~R_W_n;
  assign ctrl_wr   = reg_wr && (reg_addr_i == DMA_CTRL);
  assign busy      = (state_q != DMA_IDLE);
  assign start_cmd = ctrl_wr && data_i[CTRL_START] && !busy;
  // An ABORT written this very cycle counts too, so REQ/RD stop without an extra beat
  assign abort_now = abort_pend_q | (ctrl_wr & data_i[CTRL_ABORT] & busy);
  assign len_dec   = len_q - 16'd1;

  // State register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= DMA_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic and transfer bookkeeping strobes
  always_comb begin
    state_d    = state_q;
    step       = 1'b0;
    stop_ok    = 1'b0;
    stop_abort = 1'b0;
    unique case (state_q)
      DMA_IDLE: if (start_cmd && (len_q != '0)) state_d = DMA_REQ;
      DMA_REQ: begin
        if (abort_now) begin
          state_d    = DMA_IDLE;
          stop_abort = 1'b1;
        end else if (bus_gnt_i) begin
          state_d = fill_mode_q ? DMA_WR : DMA_RD;
        end
      end
      DMA_RD: begin
        if (abort_now) begin
          state_d    = DMA_IDLE;
          stop_abort = 1'b1;
        end else if (bus_gnt_i) begin
          state_d = DMA_RDW;
        end
      end
      DMA_RDW: state_d = DMA_WR;
      DMA_WR: begin
        if (bus_gnt_i) begin
          step = 1'b1;
          if (len_dec == '0) begin
            state_d = DMA_IDLE;
            stop_ok = 1'b1;
          end else if (abort_now) begin
            state_d    = DMA_IDLE;
            stop_abort = 1'b1;
          end else begin
            state_d = fill_mode_q ? DMA_WR : DMA_RD;
          end
        end
      end
      default: state_d = DMA_IDLE;
    endcase
  end

  // Master bus outputs decoded from the current state
  always_comb begin
    bus_req_o = busy;
    m_we_o    = 1'b0;
    m_addr_o  = '0;
    m_data_o  = '0;
    if (state_q == DMA_RD) begin
      m_addr_o = src_q;
    end else if (state_q == DMA_WR) begin
      m_addr_o = dst_q;
      m_data_o = fill_mode_q ? fill_q : buf_q;
      m_we_o   = bus_gnt_i;
    end
  end

  // Address/length/fill registers: CPU writes when idle, auto-advance after each WR
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      src_q  <= '0;
      dst_q  <= '0;
      len_q  <= '0;
      fill_q <= '0;
    end else if (step) begin
      dst_q <= dst_q + 16'd1;
      if (!fill_mode_q) src_q <= src_q + 16'd1;
      len_q <= len_dec;
    end else if (reg_wr && !busy) begin
      case (reg_addr_i)
        DMA_SRC_L: src_q[7:0]  <= data_i;
        DMA_SRC_H: src_q[15:8] <= data_i;
        DMA_DST_L: dst_q[7:0]  <= data_i;
        DMA_DST_H: dst_q[15:8] <= data_i;
        DMA_LEN_L: len_q[7:0]  <= data_i;
        DMA_LEN_H: len_q[15:8] <= data_i;
        DMA_FILL:  fill_q      <= data_i;
        default: ;
      endcase
    end
  end

  // Read data byte captured on the cycle after the source address
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)                 buf_q <= '0;
    else if (state_q == DMA_RDW)  buf_q <= m_data_i;
  end

  // Control/status flags; later assignments take priority (START over CLR_DONE, completion last)
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      fill_mode_q  <= 1'b0;
      irq_en_q     <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      abort_pend_q <= 1'b0;
      zlen_q       <= 1'b0;
    end else begin
      zlen_q <= start_cmd && (len_q == '0);
      if (ctrl_wr) begin
        irq_en_q <= data_i[CTRL_IRQ_EN];
        if (!busy)                     fill_mode_q  <= data_i[CTRL_FILL];
        if (data_i[CTRL_CLR_DONE])     done_q       <= 1'b0;
        if (data_i[CTRL_ABORT] && busy) abort_pend_q <= 1'b1;
      end
      if (start_cmd) begin
        done_q    <= 1'b0;
        aborted_q <= 1'b0;
      end
      if (zlen_q || stop_ok) done_q <= 1'b1;
      if (stop_abort) begin
        done_q    <= 1'b1;
        aborted_q <= 1'b1;
      end
      if (stop_ok || stop_abort) abort_pend_q <= 1'b0;
    end
  end

  // Register read mux
  always_comb begin
    ctrl_rd               = '0;
    ctrl_rd[CTRL_BUSY]    = busy;
    ctrl_rd[CTRL_DONE]    = done_q;
    ctrl_rd[CTRL_ABORTED] = aborted_q;
    ctrl_rd[CTRL_IRQ_EN]  = irq_en_q;
    ctrl_rd[CTRL_FILL]    = fill_mode_q;
    case (reg_addr_i)
      DMA_SRC_L: data_o = src_q[7:0];
      DMA_SRC_H: data_o = src_q[15:8];
      DMA_DST_L: data_o = dst_q[7:0];
      DMA_DST_H: data_o = dst_q[15:8];
      DMA_LEN_L: data_o = len_q[7:0];
      DMA_LEN_H: data_o = len_q[15:8];
      DMA_CTRL:  data_o = ctrl_rd;
      DMA_FILL:  data_o = fill_q;
      default:   data_o = '0;
    endcase
  end

  assign irq_o = done_q & irq_en_q;

endmodule

// File: doc/dma_engine.md
DMA_ENGINE -- requirements
Module: dma_engine

Interface
REQ-001 The clk_i input SHALL be 1 bit wide and act as the single system clock; all state SHALL change on its rising edge.
REQ-002 The rst_n_i input SHALL be 1 bit wide and act as an asynchronous, active-low reset.
REQ-003 The R_W_n input SHALL be 1 bit wide, registered by the top one cycle after the CPU address, and SHALL mean 1 = read, 0 = write.
REQ-004 The reg_addr_i input SHALL be 4 bits wide and select the register, taken from the registered CPU address.
REQ-005 The data_i input SHALL be 8 bits wide and carry CPU write data.
REQ-006 The dma_cs input SHALL be 1 bit wide and select this block from the address decoder.
REQ-007 The data_o output SHALL be 8 bits wide and carry register read data.
REQ-008 The bus_req_o output SHALL be 1 bit wide and request bus mastership, which stalls the CPU.
REQ-009 The bus_gnt_i input SHALL be 1 bit wide and mean the arbiter grants the bus to this block.
REQ-010 The m_addr_o output SHALL be 16 bits wide and carry the master address.
REQ-011 The m_data_i input SHALL be 8 bits wide and carry synchronous memory read data, valid one cycle after the address.
REQ-012 The m_data_o output SHALL be 8 bits wide and carry master write data.
REQ-013 The m_we_o output SHALL be 1 bit wide and act as the master write strobe.
REQ-014 The irq_o output SHALL be 1 bit wide and act as a level completion interrupt.

Function
REQ-015 Register map: 0 SRC_L, 1 SRC_H, 2 DST_L, 3 DST_H, 4 LEN_L, 5 LEN_H, 6 CTRL, 7 FILL; offsets 8-15 SHALL read 0x00 and ignore writes.
REQ-016 A register write SHALL occur on the clock edge where dma_cs=1 and R_W_n=0.
REQ-017 data_o SHALL be a combinational function of reg_addr_i.
REQ-018 CTRL write bits: b0 START, b1 FILL mode, b2 IRQ_EN, b3 ABORT, b6 CLR_DONE; CTRL read: b7 BUSY, b6 DONE, b5 ABORTED, b2 IRQ_EN, b1 FILL mode.
REQ-019 While BUSY, writes to offsets 0-5 and 7 SHALL be ignored, and a START write SHALL be ignored.
REQ-020 FSM states SHALL be IDLE, REQ, RD, RDW and WR.
REQ-021 START in IDLE SHALL clear DONE and ABORTED; if LEN=0 it SHALL set DONE next cycle with no bus request, otherwise it SHALL enter REQ.
REQ-022 In REQ, bus_req_o SHALL be 1; on bus_gnt_i=1 the FSM SHALL move to WR in fill mode, otherwise to RD.
REQ-023 In RD, m_addr_o SHALL be SRC and m_we_o 0; in RDW, m_data_i SHALL be latched into a byte buffer.
REQ-024 In WR, m_addr_o SHALL be DST, m_we_o 1, and m_data_o SHALL be the buffer (copy) or FILL (fill).
REQ-025 After WR, SRC (copy only) and DST SHALL increment mod 2^16 (0xFFFF wraps to 0x0000) and LEN SHALL decrement.
REQ-026 After WR, when the decremented LEN equals 0, the FSM SHALL enter IDLE, drop bus_req_o, and set DONE.
REQ-027 After WR with LEN nonzero, the FSM SHALL return to RD (copy) or stay in WR (fill).
REQ-028 Throughput SHALL be 3 cycles/byte for copy and 1 cycle/byte for fill.
REQ-029 bus_req_o SHALL stay 1 from REQ until return to IDLE.
REQ-030 While bus_gnt_i=0, RD and WR SHALL hold state with m_we_o forced 0; RDW SHALL always complete.
REQ-031 An ABORT write while BUSY SHALL take effect at the next WR completion (or immediately in REQ/RD): the FSM SHALL go to IDLE and set DONE and ABORTED, with SRC/DST/LEN holding residual values.
REQ-032 An ABORT write in IDLE SHALL be ignored.
REQ-033 START and CLR_DONE set in the same write SHALL resolve as START.
REQ-034 irq_o SHALL equal DONE AND IRQ_EN.
REQ-035 Outside WR, m_we_o SHALL be 0; outside RD/WR, m_addr_o and m_data_o SHALL be 0.

Reset
REQ-036 Asserting rst_n_i low SHALL asynchronously force all registers to 0x00, the FSM to IDLE, and bus_req_o, m_we_o, m_addr_o, m_data_o and irq_o to 0.
REQ-037 Reset mid-transfer SHALL abandon the transfer immediately with no further write strobe.

Structure
REQ-038 Register offsets, CTRL bit positions and the FSM state encoding SHALL reside in the shared package nano6502_pkg.
REQ-039 The block SHALL be a single module with no sub-module.

Verification
REQ-040 The bench SHALL cover copy: SRC=0x1000, DST=0x2000, LEN=4, START -> bytes copied, DONE=1, SRC=0x1004, DST=0x2004, 12 granted cycles.
REQ-041 The bench SHALL cover fill: DST=0xFFFE, LEN=3, FILL=0xA5, CTRL=0x03 -> 0xA5 written at 0xFFFE, 0xFFFF, 0x0000, 3 WR cycles.
REQ-042 The bench SHALL cover LEN=0: START -> DONE=1, bus_req_o never asserted.
REQ-043 The bench SHALL cover grant gap: bus_gnt_i low 5 cycles during a copy -> no m_we_o pulses during the gap, data correct, byte count exact.
REQ-044 The bench SHALL cover abort: LEN=0x100 copy, ABORT after 2 bytes -> ABORTED=1, LEN=0x00FE; irq_o=1 when IRQ_EN=1, cleared by CLR_DONE.
REQ-045 The bench SHALL cover reset: rst_n_i low mid-WR -> bus_req_o and m_we_o low immediately, all registers read 0x00.
